// File: rtl/envelope_shaper.sv
// envelope_shaper: applies an 8-bit attack/sustain/release gain envelope to a
// signed 16-bit sample stream. Configuration registers arrive over a simple
// address/data write port; the envelope advances once per input sample.
// Build option: define ENVELOPE_SHAPER_RELEASE_EN to enable the RELEASE ramp.
// Without it, key-off drops the level to silence at the next sample.
module envelope_shaper (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [15:0] data_in,
    input  logic [3:0]  addr_in,
    input  logic        data_valid_in,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    output logic [15:0] sample_out,
    output logic        sample_valid_out,
    output logic [1:0]  env_state_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } env_state_t;

    localparam logic [3:0] ADDR_KEY     = 4'hC;
    localparam logic [3:0] ADDR_ATTACK  = 4'hD;
`ifdef ENVELOPE_SHAPER_RELEASE_EN
    localparam logic [3:0] ADDR_RELEASE = 4'hE;
`endif
    localparam logic [3:0] ADDR_TARGET  = 4'hF;

    // Configuration registers
    logic        key_q;
    logic [7:0]  attack_rate_q;
    logic [7:0]  target_q;
`ifdef ENVELOPE_SHAPER_RELEASE_EN
    logic [7:0]  release_rate_q;
    logic [8:0]  release_diff;
`endif

    // Envelope state
    env_state_t  state_q, state_d, step_state;
    logic [7:0]  level_q, level_d;
    logic        key_seen_q, key_seen_d;   // key value seen at the previous update
    logic [8:0]  attack_sum;

    // Gain pipeline
    logic signed [24:0] sample_ext;
    logic signed [24:0] level_ext;
    logic signed [24:0] prod_d;
    logic signed [24:0] prod_q;
    logic               valid1_q;
    logic [15:0]        sample_out_q;
    logic               valid_out_q;
    logic               unused_bits;

    // Register writes; a write landing on a sample strobe only takes effect
    // from the following strobe because the update logic reads the _q values.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            key_q          <= 1'b0;
            attack_rate_q  <= 8'h01;
            target_q       <= 8'hFF;
`ifdef ENVELOPE_SHAPER_RELEASE_EN
            release_rate_q <= 8'h01;
`endif
        end else if (data_valid_in) begin
            case (addr_in)
                ADDR_KEY:     key_q          <= data_in[0];
                ADDR_ATTACK:  attack_rate_q  <= data_in[7:0];
`ifdef ENVELOPE_SHAPER_RELEASE_EN
                ADDR_RELEASE: release_rate_q <= data_in[7:0];
`endif
                ADDR_TARGET:  target_q       <= data_in[7:0];
                default:      ;
            endcase
        end
    end

    // Envelope state, level and key-edge tracking registers
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= S_IDLE;
            level_q    <= 8'h00;
            key_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            key_seen_q <= key_seen_d;
        end
    end

    // Next envelope state/level: key edges pick the state whose step is applied
    // at this strobe, then that state's step computes the new level.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        key_seen_d = key_seen_q;
        step_state = state_q;
        attack_sum = {1'b0, level_q} + {1'b0, attack_rate_q};
`ifdef ENVELOPE_SHAPER_RELEASE_EN
        release_diff = {1'b0, level_q} - {1'b0, release_rate_q};
`endif
        if (sample_valid_in) begin
            key_seen_d = key_q;
            if (key_q && !key_seen_q) begin
                step_state = S_ATTACK;
            end else if (!key_q && key_seen_q &&
                         (state_q == S_ATTACK || state_q == S_SUSTAIN)) begin
`ifdef ENVELOPE_SHAPER_RELEASE_EN
                step_state = S_RELEASE;
`else
                step_state = S_IDLE;
`endif
            end
            case (step_state)
                S_ATTACK: begin
                    // Saturate at target; also covers a target below the level.
                    if (attack_rate_q == 8'h00 || attack_sum >= {1'b0, target_q}) begin
                        level_d = target_q;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = attack_sum[7:0];
                        state_d = S_ATTACK;
                    end
                end
                S_SUSTAIN: begin
                    level_d = target_q;
                    state_d = S_SUSTAIN;
                end
                S_RELEASE: begin
`ifdef ENVELOPE_SHAPER_RELEASE_EN
                    // Borrow out of bit 8 means the step would go below zero.
                    if (release_rate_q == 8'h00 || release_diff[8] ||
                        release_diff[7:0] == 8'h00) begin
                        level_d = 8'h00;
                        state_d = S_IDLE;
                    end else begin
                        level_d = release_diff[7:0];
                        state_d = S_RELEASE;
                    end
`else
                    level_d = 8'h00;
                    state_d = S_IDLE;
`endif
                end
                default: begin
                    level_d = 8'h00;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Signed sample times unsigned level; the product uses the pre-update level.
    assign sample_ext = {{9{sample_in[15]}}, sample_in};
    assign level_ext  = {17'd0, level_q};
    assign prod_d     = sample_ext * level_ext;

    // Two-stage output pipeline: multiply, then shift/hold register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            valid1_q     <= 1'b0;
            prod_q       <= '0;
            valid_out_q  <= 1'b0;
            sample_out_q <= 16'h0000;
        end else begin
            valid1_q    <= sample_valid_in;
            valid_out_q <= valid1_q;
            if (sample_valid_in) begin
                prod_q <= prod_d;
            end
            // Taking bits [23:8] of the two's-complement product is an
            // arithmetic shift by 8 that rounds toward minus infinity.
            if (valid1_q) begin
                sample_out_q <= prod_q[23:8];
            end
        end
    end

    assign sample_out       = sample_out_q;
    assign sample_valid_out = valid_out_q;
    assign env_state_out    = state_q;

    assign unused_bits = ^{data_in[15:8], prod_q[24], prod_q[7:0]};

endmodule

// File: tb/tb_envelope_shaper.sv
// tb_envelope_shaper: directed stimulus for envelope_shaper with a behavioural
// envelope model feeding an expected-output scoreboard.
module tb_envelope_shaper;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  addr_in = 4'h0;
    logic        data_valid_in = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic        sample_valid_in = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic [1:0]  env_state_out;

    envelope_shaper dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .data_in          (data_in),
        .addr_in          (addr_in),
        .data_valid_in    (data_valid_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .env_state_out    (env_state_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    localparam int ST_IDLE = 0, ST_ATK = 1, ST_SUS = 2, ST_REL = 3;

    typedef struct {
        logic [15:0] out;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    logic [15:0] last_out = 16'h0;

    // Envelope model
    int m_level, m_state, m_att, m_rel, m_tgt;
    bit m_key, m_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_level = 0; m_state = ST_IDLE; m_att = 1; m_rel = 1; m_tgt = 255;
        m_key = 1'b0; m_seen = 1'b0;
    endfunction

    function automatic logic [15:0] model_output(input logic [15:0] s);
        int p;
        p = int'($signed(s)) * m_level;
        p = p >>> 8;
        return p[15:0];
    endfunction

    function automatic void model_strobe();
        int st;
        int nxt;
        st = m_state;
        if (m_key && !m_seen) begin
            st = ST_ATK;
        end else if (!m_key && m_seen && (st == ST_ATK || st == ST_SUS)) begin
`ifdef ENVELOPE_SHAPER_RELEASE_EN
            st = ST_REL;
`else
            st = ST_IDLE;
`endif
        end
        case (st)
            ST_ATK: begin
                nxt = m_level + m_att;
                if (nxt > m_tgt || m_att == 0) nxt = m_tgt;
                m_level = nxt;
                m_state = (m_level == m_tgt) ? ST_SUS : ST_ATK;
            end
            ST_SUS: begin
                m_level = m_tgt;
                m_state = ST_SUS;
            end
            ST_REL: begin
                nxt = m_level - m_rel;
                if (nxt < 0 || m_rel == 0) nxt = 0;
                m_level = nxt;
                m_state = (m_level == 0) ? ST_IDLE : ST_REL;
            end
            default: begin
                m_level = 0;
                m_state = ST_IDLE;
            end
        endcase
        m_seen = m_key;
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'hC: m_key = d[0];
            4'hD: m_att = int'(d);
`ifdef ENVELOPE_SHAPER_RELEASE_EN
            4'hE: m_rel = int'(d);
`endif
            4'hF: m_tgt = int'(d);
            default: ;
        endcase
    endfunction

    // One cycle of stimulus; the model sees the strobe before a coincident write.
    task automatic step(input bit sv, input logic [15:0] s, input bit dv,
                        input logic [3:0] a, input logic [7:0] d);
        exp_t x;
        @(negedge clk_in);
        sample_valid_in = sv;
        sample_in       = s;
        data_valid_in   = dv;
        addr_in         = a;
        data_in         = {8'hA5, d};
        if (sv) begin
            x.out = model_output(s);
            x.due = cyc + 2;
            sb.push_back(x);
            model_strobe();
        end
        if (dv) model_write(a, d);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b0, 16'h0, 1'b1, a, d);
    endtask

    task automatic strobe(input logic [15:0] s);
        step(1'b1, s, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic check_state(input string tag);
        idle(1);
        check(tag, {30'd0, env_state_out}, m_state);
    endtask

    // Output monitor: pops the scoreboard on each valid and checks latency/hold.
    always @(negedge clk_in) begin
        if (!reset_in) begin
            last_out = 16'h0;
        end else if (sample_valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sample_out", {16'd0, sample_out}, {16'd0, e.out});
                check("latency", cyc, e.due);
            end
            last_out = sample_out;
        end else begin
            check("hold", {16'd0, sample_out}, {16'd0, last_out});
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk_in);
        check("rst_out", {16'd0, sample_out}, 32'd0);
        check("rst_valid", {31'd0, sample_valid_out}, 32'd0);
        check("rst_state", {30'd0, env_state_out}, ST_IDLE);
        reset_in = 1'b1;

        // Idle envelope mutes the sample
        strobe(16'h4000);
        check_state("idle_state");
        idle(3);

        // Attack ramp into sustain, first spaced then back-to-back
        wr(4'h3, 8'h00);
        wr(4'hD, 8'h40);
        wr(4'hF, 8'hFF);
        wr(4'hC, 8'h01);
        strobe(16'h4000);
        check_state("attack_state");
        strobe(16'h4000);
        strobe(16'h4000);
        strobe(16'h4000);
        strobe(16'h4000);
        check_state("sustain_state");

        // Target write coincident with a strobe uses the old target
        step(1'b1, 16'h4000, 1'b1, 4'hF, 8'h80);
        strobe(16'h4000);
        strobe(16'h4000);
        check_state("sustain_follow");
        wr(4'hF, 8'hFF);
        strobe(16'h4000);
        strobe(16'h7FFF);

        // Key off with release rate 0x80
        wr(4'hE, 8'h80);
        wr(4'hC, 8'h00);
        strobe(16'h8000);
        check_state("keyoff_state");
        strobe(16'h8000);
        strobe(16'h8000);
        strobe(16'h8000);
        check_state("release_done");
        idle(2);

        // Attack rate 0 jumps to target; release rate 0 drops to zero
        wr(4'hD, 8'h00);
        wr(4'hF, 8'h60);
        step(1'b1, 16'h1234, 1'b1, 4'hC, 8'h01);   // key write coincident: old key used
        strobe(16'h1234);
        check_state("atk0_state");
        wr(4'hE, 8'h00);
        wr(4'hC, 8'h00);
        strobe(16'hFFFF);
        check_state("rel0_state");

        // Target below current level during attack
        wr(4'hD, 8'h10);
        wr(4'hF, 8'hF0);
        wr(4'hC, 8'h01);
        strobe(16'h8001);
        strobe(16'h8001);
        strobe(16'h8001);
        wr(4'hF, 8'h20);
        strobe(16'hC000);
        check_state("below_target");

        // Key off then key on again part way down
        wr(4'hE, 8'h08);
        wr(4'hC, 8'h00);
        strobe(16'h2000);
        wr(4'hC, 8'h01);
        strobe(16'h2000);
        check_state("rekey_state");
        for (int i = 0; i < 20; i++) strobe(16'($urandom));
        check_state("burst_state");

        // Reset one cycle after a strobe discards it
        strobe(16'h7FFF);
        @(negedge clk_in);
        reset_in = 1'b0;
        sample_valid_in = 1'b0;
        data_valid_in = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check("midrst_valid", {31'd0, sample_valid_out}, 32'd0);
        check("midrst_out", {16'd0, sample_out}, 32'd0);
        check("midrst_state", {30'd0, env_state_out}, ST_IDLE);
        @(negedge clk_in);
        reset_in = 1'b1;
        idle(4);

        // Key off from full sustain
        wr(4'hD, 8'h00);
        wr(4'hC, 8'h01);
        strobe(16'h4000);
        strobe(16'h4000);
        wr(4'hC, 8'h00);
        strobe(16'h4000);
        check_state("keyoff_full");
        strobe(16'h4000);
        strobe(16'h4000);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        check("drain", sb.size(), 0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
